// File: rtl/playback_control_pkg.sv
// Shared constants for the playback controller, song reader and tests.
// State encoding lives here so every consumer agrees on it.
package playback_control_pkg;

  typedef enum logic [1:0] {
    PAUSED   = 2'd0,
    PLAYING  = 2'd1,
    SWITCH_P = 2'd2,
    SWITCH_R = 2'd3
  } state_t;

  localparam int DEF_NUM_SONGS  = 4;
  localparam int DEF_SONG_WIDTH = 2;

endpackage

// File: rtl/playback_control_mod_updown_counter.sv
// Modulo up/down counter holding the current song index.
// Arithmetic is one bit wider so non-power-of-two moduli wrap cleanly.
module mod_updown_counter #(
  parameter int MOD   = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0] TOP_W = (WIDTH+1)'(MOD - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH:0]   ext;
  logic [WIDTH:0]   nxt;

  always_comb begin
    ext     = {1'b0, count_q};
    nxt     = ext;
    count_d = count_q;
    if (inc) begin
      nxt = ext + 1'b1;
      if (nxt >= MOD_W) nxt = '0;
      count_d = nxt[WIDTH-1:0];
    end else if (dec) begin
      nxt = (ext == '0) ? TOP_W : ext - 1'b1;
      count_d = nxt[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/playback_control.sv
// Play/pause and song-select FSM fed by debounced one-cycle button pulses.
// Emits a one-cycle reset_player pulse whenever the song position rewinds.
import playback_control_pkg::*;

module playback_control #(
  parameter int NUM_SONGS    = DEF_NUM_SONGS,
  parameter int SONG_WIDTH   = DEF_SONG_WIDTH,
  parameter int AUTO_ADVANCE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play_button,
  input  logic                  next_button,
  input  logic                  prev_button,
  input  logic                  song_done,
  output logic                  play,
  output logic [SONG_WIDTH-1:0] song,
  output logic                  reset_player
);

  state_t state_q, state_d;
  logic   play_q, play_d;
  logic   rp_q, rp_d;
  logic   inc, dec;

  always_comb begin
    state_d = state_q;
    play_d  = play_q;
    rp_d    = 1'b0;
    inc     = 1'b0;
    dec     = 1'b0;
    case (state_q)
      PAUSED: begin
        play_d = 1'b0;
        if (play_button) begin
          state_d = PLAYING;
          play_d  = 1'b1;
        end else if (next_button) begin
          inc     = 1'b1;
          rp_d    = 1'b1;
          state_d = SWITCH_P;
        end else if (prev_button) begin
          dec     = 1'b1;
          rp_d    = 1'b1;
          state_d = SWITCH_P;
        end
      end
      PLAYING: begin
        play_d = 1'b1;
        if (play_button) begin
          state_d = PAUSED;
          play_d  = 1'b0;
        end else if (next_button) begin
          inc     = 1'b1;
          rp_d    = 1'b1;
          state_d = SWITCH_R;
        end else if (prev_button) begin
          dec     = 1'b1;
          rp_d    = 1'b1;
          state_d = SWITCH_R;
        end else if (song_done) begin
          rp_d = 1'b1;
          if (AUTO_ADVANCE != 0) begin
            inc     = 1'b1;
            state_d = SWITCH_R;
          end else begin
            play_d  = 1'b0;
            state_d = SWITCH_P;
          end
        end
      end
      SWITCH_P: begin
        state_d = PAUSED;
        play_d  = 1'b0;
      end
      SWITCH_R: begin
        state_d = PLAYING;
        play_d  = 1'b1;
      end
      default: begin
        state_d = PAUSED;
        play_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PAUSED;
      play_q  <= 1'b0;
      rp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      play_q  <= play_d;
      rp_q    <= rp_d;
    end
  end

  mod_updown_counter #(
    .MOD   (NUM_SONGS),
    .WIDTH (SONG_WIDTH)
  ) u_song (
    .clk   (clk),
    .reset (reset),
    .inc   (inc),
    .dec   (dec),
    .count (song)
  );

  assign play         = play_q;
  assign reset_player = rp_q;

endmodule

// File: tb/tb_playback_control.sv
// Directed plus random bench for playback_control against a behavioural model.
// Three instances: 4 songs no auto-advance, 4 songs auto-advance, 3 songs auto-advance.
module tb_playback_control;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic play_button = 1'b0;
  logic next_button = 1'b0;
  logic prev_button = 1'b0;
  logic song_done = 1'b0;

  logic       play_o [NI];
  logic [1:0] song_o [NI];
  logic       rp_o   [NI];

  int n_assert = 0;
  int n_fail   = 0;

  int m_play [NI];
  int m_song [NI];
  int m_rp   [NI];
  int m_busy [NI];
  int m_n    [NI] = '{4, 4, 3};
  int m_aa   [NI] = '{0, 1, 1};

  always #5 clk = ~clk;

  playback_control #(.NUM_SONGS(4), .SONG_WIDTH(2), .AUTO_ADVANCE(0)) dut0 (
    .clk(clk), .reset(reset), .play_button(play_button),
    .next_button(next_button), .prev_button(prev_button),
    .song_done(song_done), .play(play_o[0]), .song(song_o[0]),
    .reset_player(rp_o[0])
  );

  playback_control #(.NUM_SONGS(4), .SONG_WIDTH(2), .AUTO_ADVANCE(1)) dut1 (
    .clk(clk), .reset(reset), .play_button(play_button),
    .next_button(next_button), .prev_button(prev_button),
    .song_done(song_done), .play(play_o[1]), .song(song_o[1]),
    .reset_player(rp_o[1])
  );

  playback_control #(.NUM_SONGS(3), .SONG_WIDTH(2), .AUTO_ADVANCE(1)) dut2 (
    .clk(clk), .reset(reset), .play_button(play_button),
    .next_button(next_button), .prev_button(prev_button),
    .song_done(song_done), .play(play_o[2]), .song(song_o[2]),
    .reset_player(rp_o[2])
  );

  // Reference: a player is "busy" for the one cycle after any rewind,
  // and during that cycle it simply holds its play level.
  task automatic model_step(bit pb, bit nb, bit vb, bit sd, bit rst);
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        m_play[i] = 0; m_song[i] = 0; m_rp[i] = 0; m_busy[i] = 0;
      end else if (m_busy[i] != 0) begin
        m_busy[i] = 0; m_rp[i] = 0;
      end else begin
        m_rp[i] = 0;
        if (pb) begin
          m_play[i] = (m_play[i] == 0) ? 1 : 0;
        end else if (nb) begin
          m_song[i] = (m_song[i] + 1) % m_n[i];
          m_rp[i] = 1; m_busy[i] = 1;
        end else if (vb) begin
          m_song[i] = (m_song[i] + m_n[i] - 1) % m_n[i];
          m_rp[i] = 1; m_busy[i] = 1;
        end else if (sd && m_play[i] != 0) begin
          m_rp[i] = 1; m_busy[i] = 1;
          if (m_aa[i] != 0) m_song[i] = (m_song[i] + 1) % m_n[i];
          else              m_play[i] = 0;
        end
      end
    end
  endtask

  task automatic chk(string tag, int obs, int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(bit pb, bit nb, bit vb, bit sd, bit rst);
    play_button = pb; next_button = nb; prev_button = vb;
    song_done = sd; reset = rst;
    @(posedge clk);
    model_step(pb, nb, vb, sd, rst);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("play[%0d]", i), int'(play_o[i]), m_play[i]);
      chk($sformatf("song[%0d]", i), int'(song_o[i]), m_song[i]);
      chk($sformatf("reset_player[%0d]", i), int'(rp_o[i]), m_rp[i]);
    end
    play_button = 0; next_button = 0; prev_button = 0;
    song_done = 0; reset = 0;
  endtask

  int r;
  bit rb;

  initial begin
    // reset state
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("reset_song_const", int'(song_o[1]), 0);
    // play toggles with no rewind pulse
    cyc(1, 0, 0, 0, 0);
    chk("play_on_const", int'(play_o[1]), 1);
    chk("no_rp_on_play", int'(rp_o[1]), 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("play_off_const", int'(play_o[1]), 0);
    // play and next together while paused: play wins
    cyc(1, 1, 0, 0, 0);
    chk("prio_song", int'(song_o[1]), 0);
    chk("prio_rp", int'(rp_o[1]), 0);
    // prev wraps 0 -> last, then next wraps back
    cyc(0, 0, 1, 0, 0);
    chk("prev_wrap4", int'(song_o[1]), 3);
    chk("prev_wrap3", int'(song_o[2]), 2);
    cyc(0, 0, 0, 0, 0);
    chk("rp_one_cycle", int'(rp_o[1]), 0);
    chk("play_in_switch", int'(play_o[1]), 1);
    cyc(0, 1, 0, 0, 0);
    chk("next_wrap4", int'(song_o[1]), 0);
    cyc(0, 0, 0, 0, 0);
    // back-to-back next: only the first counts
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("b2b_next", int'(song_o[1]), 1);
    // song_done on song 1 while playing
    cyc(0, 0, 0, 1, 0);
    chk("done_aa1_song", int'(song_o[1]), 2);
    chk("done_aa0_play", int'(play_o[0]), 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    // next issued, then reset during the switch cycle
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("rst_mid_switch_rp", int'(rp_o[1]), 0);
    cyc(0, 0, 0, 0, 0);
    // song_done while paused is ignored
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    // random traffic
    for (int k = 0; k < 600; k++) begin
      r  = $urandom_range(0, 15);
      rb = ($urandom_range(0, 99) == 0);
      cyc(r == 0 || r == 6, r == 1 || r == 5 || r == 6,
          r == 2 || r == 7, r == 3 || r == 4 || r == 7, rb);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
